addr_bus_responder: RTL and testbench
=====================================

// Module: addr_bus_responder
// PURPOSE
//  Memory-side responder for the CPU address bus. Address registers drive addr_out/addr_en.
//  This block samples the bus plus active-low read/write strobes and runs one SRAM access
//  with WAIT_STATES wait cycles. For a read it returns data onto the xfer bus with an enable.
//  Sits between the address/xfer buses and the external RAM/ROM array; busy stalls the sequencer.
// PARAMETERS
//  ADDR_WIDTH   16       address bus width in bits
//  DATA_WIDTH   8        data (xfer) bus width in bits
//  WAIT_STATES  1        extra access cycles, 0..15; access phase lasts WAIT_STATES+1 cycles
//  ROM_TOP      16'h1FFF highest read-only address; writes at or below it are dropped
// PORTS
//  clk        in   1   system clock, all state changes on posedge
//  reset      in   1   one clock; reset is asynchronous and active-high
//  addr_in    in   AW  address bus value
//  addr_en    in   1   address bus driven (active-high)
//  data_in    in   DW  xfer bus value (write data)
//  read_n     in   1   read strobe, active-low
//  write_n    in   1   write strobe, active-low
//  data_out   out  DW  read data to xfer bus
//  data_en    out  1   data_out valid / drive xfer bus (active-high)
//  busy       out  1   access in progress; sequencer must hold strobes/address
//  err        out  1   one-cycle pulse: illegal request (both strobes low)
//  ram_addr   out  AW  SRAM address
//  ram_wdata  out  DW  SRAM write data
//  ram_rdata  in   DW  SRAM read data, valid while ram_oe high
//  ram_we     out  1   SRAM write enable (active-high)
//  ram_oe     out  1   SRAM output enable (active-high)
// BEHAVIOUR
//  - Reset (async): state=IDLE. data_out=0, ram_addr=0, ram_wdata=0. wait count=0.
//    data_en=busy=err=ram_we=ram_oe=0.
//  - States IDLE, ACCESS, HOLD. All outputs are registered.
//  - IDLE: request = addr_en & (read_n ^ write_n). On request, latch addr_in to ram_addr,
//    data_in to ram_wdata and op=read/write. Load cnt=WAIT_STATES, set busy, go ACCESS.
//  - IDLE with addr_en & !read_n & !write_n: pulse err for 1 cycle, stay IDLE, no RAM strobe.
//  - Strobes with addr_en=0 are ignored. No err.
//  - ACCESS: ram_oe=1 (read) or ram_we=1 (write, only if ram_addr > ROM_TOP).
//    If cnt!=0, decrement. If cnt==0: read -> data_out<=ram_rdata, data_en=1.
//    Then drop ram_oe/ram_we, clear busy and go HOLD.
//  - Latency: request sampled at edge N. Access strobes are high for cycles N+1..N+WAIT_STATES+1.
//    data_en rises at edge N+WAIT_STATES+2.
//  - ROM write (addr<=ROM_TOP): full cycle timing kept, busy behaves normally, ram_we stays 0.
//  - HOLD: data_en holds while read_n=0 (read op). Exit to IDLE on the first cycle with
//    read_n=1 & write_n=1. data_en clears on that same edge; data_out keeps its value.
//    A new request needs the strobes to return high first, so there is exactly one access per strobe.
//  - Strobe/address changes during ACCESS are ignored; latched values are used.
//  - Reset mid-access: immediate return to IDLE. ram_we/ram_oe drop asynchronously; no partial write is held.
//  - Counter width $clog2(WAIT_STATES+1), minimum 1 bit. It never wraps: decrement only when nonzero.
// STRUCTURE
//  - Shared package: state encoding (IDLE=2'd0, ACCESS=2'd1, HOLD=2'd2), op enum (OP_READ, OP_WRITE).
//  - Single module. Optional sub-module wait_counter (load/decrement/zero flag) is reusable by
//    other bus slaves.
//  - Illegal state 2'd3 recovers to IDLE with all strobes low.
// TESTING
//  - Read, WAIT_STATES=1, addr 16'h4000, ram_rdata=8'hA5: ram_oe high 2 cycles,
//    data_en at edge N+3 with data_out=8'hA5, busy low by then.
//  - Write addr 16'h4001, data 8'h3C: ram_we high 2 cycles with ram_addr=16'h4001,
//    ram_wdata=8'h3C; back to IDLE once write_n=1.
//  - Write addr 16'h0010 (ROM): ram_we never asserts; busy high 3 cycles, same timing as a RAM write.
//  - read_n=write_n=0 with addr_en=1: err pulses 1 cycle, busy/ram_oe/ram_we stay 0.
//  - Hold read_n low 5 cycles after completion: data_en stays high, only one ram_oe burst.
//    Release -> data_en low next edge.
//  - Assert reset mid-ACCESS (write): ram_we drops without a clock edge. All outputs at reset values.
//    A subsequent read completes normally.

Source files
------------

// File: rtl/addr_bus_responder_pkg.sv
// Shared types for the address-bus responder: FSM state encoding, operation kind,
// and a helper that sizes the wait-state counter.
package addr_bus_responder_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StHold   = 2'd2
    } state_e;

    typedef enum logic {
        OpRead  = 1'b0,
        OpWrite = 1'b1
    } op_e;

    // Wait counter width: enough bits for 0..ws, never less than one bit.
    function automatic int unsigned cnt_width(int unsigned ws);
        return (ws == 0) ? 1 : $clog2(ws + 1);
    endfunction

endpackage

// File: rtl/addr_bus_responder_if.sv
// CPU address/xfer bus plus SRAM side signals seen by the responder.
// slave: the responder itself; master: whatever drives the bus and models the SRAM.
interface addr_bus_responder_if #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] addr_in;
    logic                  addr_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  read_n;
    logic                  write_n;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_en;
    logic                  busy;
    logic                  err;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic                  ram_we;
    logic                  ram_oe;

    modport slave (
        input  addr_in, addr_en, data_in, read_n, write_n, ram_rdata,
        output data_out, data_en, busy, err, ram_addr, ram_wdata, ram_we, ram_oe
    );

    modport master (
        output addr_in, addr_en, data_in, read_n, write_n, ram_rdata,
        input  data_out, data_en, busy, err, ram_addr, ram_wdata, ram_we, ram_oe
    );
endinterface

// File: rtl/addr_bus_responder_wait_counter.sv
// Loadable down-counter with zero flag; saturates at zero instead of wrapping.
// Generic enough to pace any bus slave's wait states.
module addr_bus_responder_wait_counter #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);
    logic [WIDTH-1:0] cnt_q;

    // Load takes priority over decrement; decrement only while nonzero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero = (cnt_q == '0);
endmodule

// File: rtl/addr_bus_responder.sv
// Memory-side responder: samples one strobe-qualified request from the CPU bus, runs a
// single SRAM access lasting WAIT_STATES+1 strobe cycles, returns read data on the xfer
// bus and holds it until the strobes are released. Writes into the ROM window are
// timed like real writes but never strobe the SRAM.
module addr_bus_responder
    import addr_bus_responder_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH  = 16,
    parameter int unsigned           DATA_WIDTH  = 8,
    parameter int unsigned           WAIT_STATES = 1,
    parameter logic [ADDR_WIDTH-1:0] ROM_TOP     = 'h1FFF
) (
    input  logic                 clk,
    input  logic                 reset,
    addr_bus_responder_if.slave  bus
);
    localparam int unsigned           CntWidth = cnt_width(WAIT_STATES);
    localparam logic [CntWidth-1:0]   WaitLoad = CntWidth'(WAIT_STATES);

    state_e                state_q;
    op_e                   op_q;
    // Set on the first ACCESS cycle once the SRAM strobe has been raised.
    logic                  armed_q;
    logic [DATA_WIDTH-1:0] data_out_q;
    logic                  data_en_q;
    logic                  busy_q;
    logic                  err_q;
    logic [ADDR_WIDTH-1:0] ram_addr_q;
    logic [DATA_WIDTH-1:0] ram_wdata_q;
    logic                  ram_we_q;
    logic                  ram_oe_q;

    logic request;
    logic illegal;
    logic cnt_load;
    logic cnt_dec;
    logic cnt_zero;

    // Request decode and wait-counter control.
    always_comb begin
        request  = bus.addr_en & (bus.read_n ^ bus.write_n);
        illegal  = bus.addr_en & ~bus.read_n & ~bus.write_n;
        cnt_load = (state_q == StIdle) && request;
        cnt_dec  = (state_q == StAccess) && armed_q && !cnt_zero;
    end

    addr_bus_responder_wait_counter #(
        .WIDTH (CntWidth)
    ) u_wait_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (WaitLoad),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // Access sequencer; every bus and SRAM output is a register of this FSM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            op_q        <= OpRead;
            armed_q     <= 1'b0;
            data_out_q  <= '0;
            data_en_q   <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_we_q    <= 1'b0;
            ram_oe_q    <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (request) begin
                        ram_addr_q  <= bus.addr_in;
                        ram_wdata_q <= bus.data_in;
                        op_q        <= bus.read_n ? OpWrite : OpRead;
                        armed_q     <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= StAccess;
                    end else if (illegal) begin
                        err_q <= 1'b1;
                    end
                end
                StAccess: begin
                    if (!armed_q) begin
                        armed_q <= 1'b1;
                        if (op_q == OpRead) begin
                            ram_oe_q <= 1'b1;
                        end else begin
                            ram_we_q <= (ram_addr_q > ROM_TOP);
                        end
                    end else if (cnt_zero) begin
                        if (op_q == OpRead) begin
                            data_out_q <= bus.ram_rdata;
                            data_en_q  <= 1'b1;
                        end
                        ram_oe_q <= 1'b0;
                        ram_we_q <= 1'b0;
                        busy_q   <= 1'b0;
                        armed_q  <= 1'b0;
                        state_q  <= StHold;
                    end
                end
                StHold: begin
                    // One access per strobe: wait for both strobes to go high.
                    if (bus.read_n && bus.write_n) begin
                        data_en_q <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    armed_q   <= 1'b0;
                    data_en_q <= 1'b0;
                    busy_q    <= 1'b0;
                    ram_we_q  <= 1'b0;
                    ram_oe_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_out  = data_out_q;
    assign bus.data_en   = data_en_q;
    assign bus.busy      = busy_q;
    assign bus.err       = err_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = ram_wdata_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_oe    = ram_oe_q;
endmodule

// File: tb/tb_addr_bus_responder.sv
// Bench for addr_bus_responder with WAIT_STATES=1: table of single transfers plus
// hand-written error, ignore and mid-access reset sequences. Read data and RAM writes
// are checked by a scoreboard as the DUT produces them.
module tb_addr_bus_responder;
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 8;
    localparam int unsigned WS = 1;
    localparam logic [AW-1:0] RomTop = 16'h1FFF;

    logic clk;
    logic reset;

    addr_bus_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    addr_bus_responder #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .WAIT_STATES (WS),
        .ROM_TOP     (RomTop)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    // Scoreboard queues: expected read data, expected RAM write {addr, data}.
    logic [DW-1:0]    rd_q[$];
    logic [AW+DW-1:0] wr_q[$];

    logic prev_en = 1'b0;
    logic prev_we = 1'b0;

    always @(negedge clk) begin
        if (bus.data_en && !prev_en) begin
            if (rd_q.size() == 0) begin
                check("unexpected_data_en", 32'(bus.data_en), 32'd0);
            end else begin
                check("read_data", 32'(bus.data_out), 32'(rd_q.pop_front()));
            end
        end
        if (bus.ram_we && !prev_we) begin
            if (wr_q.size() == 0) begin
                check("unexpected_ram_we", 32'(bus.ram_we), 32'd0);
            end else begin
                check("write_addr_data", 32'({bus.ram_addr, bus.ram_wdata}),
                      32'(wr_q.pop_front()));
            end
        end
        prev_en = bus.data_en;
        prev_we = bus.ram_we;
    end

    typedef struct {
        logic          is_read;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        int            hold;
        int            exp_busy;
        int            exp_oe;
        int            exp_we;
    } vec_t;

    task automatic do_xfer(input vec_t v);
        int  busy_cyc = 0;
        int  oe_cyc   = 0;
        int  we_cyc   = 0;
        bit  done     = 0;
        bit  hold_ok  = 1;
        @(negedge clk);
        bus.addr_en   = 1'b1;
        bus.addr_in   = v.addr;
        bus.data_in   = v.wdata;
        bus.read_n    = ~v.is_read;
        bus.write_n   = v.is_read;
        bus.ram_rdata = v.rdata;
        if (v.is_read) rd_q.push_back(v.rdata);
        else if (v.addr > RomTop) wr_q.push_back({v.addr, v.wdata});
        for (int i = 1; i <= 40 && !done; i++) begin
            @(negedge clk);
            // Bus moves after the request edge; the latched values must win.
            if (i == 1) begin
                bus.addr_in = ~v.addr;
                bus.data_in = ~v.wdata;
            end
            if (bus.ram_oe) oe_cyc++;
            if (bus.ram_we) we_cyc++;
            if (bus.busy) busy_cyc++;
            else done = 1;
        end
        check("busy_done", 32'(done), 32'd1);
        check("busy_cycles", 32'(busy_cyc), 32'(v.exp_busy));
        check("data_en_at_done", 32'(bus.data_en), 32'(v.is_read));
        check("oe_cycles", 32'(oe_cyc), 32'(v.exp_oe));
        check("we_cycles", 32'(we_cyc), 32'(v.exp_we));
        bus.ram_rdata = ~v.rdata;
        for (int i = 0; i < v.hold; i++) begin
            @(negedge clk);
            if (bus.data_en !== v.is_read || bus.ram_oe || bus.ram_we || bus.busy) hold_ok = 0;
        end
        if (v.hold > 0) check("hold_stable", 32'(hold_ok), 32'd1);
        bus.read_n  = 1'b1;
        bus.write_n = 1'b1;
        bus.addr_en = 1'b0;
        @(negedge clk);
        check("data_en_release", 32'(bus.data_en), 32'd0);
        if (v.is_read) check("data_out_kept", 32'(bus.data_out), 32'(v.rdata));
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{1'b1, 16'h4000, 8'h00, 8'hA5, 5, 3, 2, 0};
        vecs[1] = '{1'b0, 16'h4001, 8'h3C, 8'h00, 0, 3, 0, 2};
        vecs[2] = '{1'b0, 16'h0010, 8'h99, 8'h00, 0, 3, 0, 0};
        vecs[3] = '{1'b1, 16'h0010, 8'h00, 8'h5A, 0, 3, 2, 0};
        vecs[4] = '{1'b0, 16'h2000, 8'hE1, 8'h00, 3, 3, 0, 2};
        vecs[5] = '{1'b0, 16'h1FFF, 8'h42, 8'h00, 0, 3, 0, 0};
        vecs[6] = '{1'b1, 16'hFFFF, 8'h00, 8'hC3, 2, 3, 2, 0};

        reset         = 1'b1;
        bus.addr_en   = 1'b0;
        bus.addr_in   = '0;
        bus.data_in   = '0;
        bus.read_n    = 1'b1;
        bus.write_n   = 1'b1;
        bus.ram_rdata = '0;
        #12;
        check("reset_outputs", 32'({bus.data_en, bus.busy, bus.err, bus.ram_we, bus.ram_oe}),
              32'd0);
        check("reset_regs", 32'({bus.data_out, bus.ram_addr, bus.ram_wdata}), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[k]) do_xfer(vecs[k]);

        // Both strobes low with the bus driven: one err pulse, no access.
        @(negedge clk);
        bus.addr_en = 1'b1;
        bus.read_n  = 1'b0;
        bus.write_n = 1'b0;
        @(negedge clk);
        check("err_pulse", 32'(bus.err), 32'd1);
        check("err_no_access", 32'({bus.busy, bus.ram_oe, bus.ram_we}), 32'd0);
        bus.read_n  = 1'b1;
        bus.write_n = 1'b1;
        bus.addr_en = 1'b0;
        @(negedge clk);
        check("err_cleared", 32'(bus.err), 32'd0);

        // Strobe without addr_en is ignored.
        bus.read_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("ignored_no_addr_en", 32'({bus.busy, bus.ram_oe, bus.err}), 32'd0);
        end
        bus.read_n = 1'b1;

        // Reset during a RAM write: ram_we must fall without a clock edge.
        @(negedge clk);
        bus.addr_en = 1'b1;
        bus.addr_in = 16'h4002;
        bus.data_in = 8'h77;
        bus.write_n = 1'b0;
        wr_q.push_back({16'h4002, 8'h77});
        @(negedge clk);
        @(negedge clk);
        check("midreset_we_before", 32'(bus.ram_we), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("midreset_we_async", 32'(bus.ram_we), 32'd0);
        check("midreset_outputs", 32'({bus.data_en, bus.busy, bus.err, bus.ram_oe}), 32'd0);
        check("midreset_regs", 32'({bus.data_out, bus.ram_addr, bus.ram_wdata}), 32'd0);
        bus.write_n = 1'b1;
        bus.addr_en = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        do_xfer('{1'b1, 16'h4003, 8'h00, 8'h6E, 1, 3, 2, 0});

        check("rd_queue_empty", 32'(rd_q.size()), 32'd0);
        check("wr_queue_empty", 32'(wr_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Hard stop in case a wait is never satisfied.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, expected to finish");
        $fatal(1);
    end
endmodule
